// File: rtl/lw_sha_host_sequencer.sv
// lw_sha_host_sequencer: bus-initiator front end for the lightweight SHA register slave.
// Programs CFG, streams DIN words, issues CTL start/last/abort, polls STS, reads HASH.
module lw_sha_host_sequencer #(
  parameter int unsigned BUS_DATA_WIDTH = 32,
  parameter int unsigned DIGEST_WORDS   = 8,
  parameter int unsigned POLL_TIMEOUT   = 1024,
  parameter int unsigned POLL_GAP       = 4
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,
  input  logic                      cmd_start_i,
  input  logic [3:0]                opcode_i,
  input  logic                      abort_i,
  input  logic                      msg_valid_i,
  input  logic [BUS_DATA_WIDTH-1:0] msg_data_i,
  input  logic                      msg_last_i,
  output logic                      msg_ready_o,
  output logic                      digest_valid_o,
  output logic [BUS_DATA_WIDTH-1:0] digest_word_o,
  output logic [3:0]                digest_idx_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      err_o,
  output logic [1:0]                err_code_o,
  output logic                      wr_o,
  output logic [11:0]               waddr_o,
  output logic [BUS_DATA_WIDTH-1:0] wdata_o,
  output logic [3:0]                wbyte_enable_o,
  input  logic                      wr_ack_i,
  output logic                      rd_o,
  output logic [11:0]               raddr_o,
  input  logic [BUS_DATA_WIDTH-1:0] rdata_i
);

  localparam logic [11:0] ADDR_CFG  = 12'h010;
  localparam logic [11:0] ADDR_CTL  = 12'h020;
  localparam logic [11:0] ADDR_STS  = 12'h030;
  localparam logic [11:0] ADDR_HASH = 12'h100;
  localparam logic [11:0] ADDR_DIN  = 12'h140;

  localparam int unsigned PCW = $clog2(POLL_TIMEOUT + 1);
  localparam logic [PCW-1:0] POLL_LIMIT = PCW'(POLL_TIMEOUT);
  localparam logic [7:0]     GAP_LOAD   = 8'(POLL_GAP);
  localparam logic [3:0]     IDX_LAST   = 4'(DIGEST_WORDS - 1);

  typedef enum logic [3:0] {
    ST_IDLE, ST_CFG, ST_START, ST_DATA, ST_LAST, ST_POLL_GAP,
    ST_POLL_RD, ST_POLL_CHK, ST_HASH_RD, ST_HASH_CAP, ST_ERR
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      opcode_q, opcode_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [PCW-1:0]  poll_cnt_q, poll_cnt_d, poll_inc;
  logic [7:0]      gap_cnt_q, gap_cnt_d;
  logic [3:0]      idx_q, idx_d;
  logic            abort_act;

  // abort only takes effect while a job is running and not already unwinding
  assign abort_act = abort_i && (state_q != ST_IDLE) && (state_q != ST_ERR);

  // state and job-context registers
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q    <= ST_IDLE;
      opcode_q   <= '0;
      err_code_q <= '0;
      poll_cnt_q <= '0;
      gap_cnt_q  <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      opcode_q   <= opcode_d;
      err_code_q <= err_code_d;
      poll_cnt_q <= poll_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      idx_q      <= idx_d;
    end
  end

  // next-state and counter updates
  always_comb begin
    state_d    = state_q;
    opcode_d   = opcode_q;
    err_code_d = err_code_q;
    poll_cnt_d = poll_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    idx_d      = idx_q;
    poll_inc   = (poll_cnt_q == POLL_LIMIT) ? poll_cnt_q : poll_cnt_q + 1'b1;
    if (abort_act) begin
      state_d    = ST_ERR;
      err_code_d = 2'b11;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_start_i) begin
            opcode_d   = opcode_i;
            err_code_d = '0;
            state_d    = ST_CFG;
          end
        end
        ST_CFG:   state_d = ST_START;
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          if (msg_valid_i && wr_ack_i && msg_last_i) state_d = ST_LAST;
        end
        ST_LAST: begin
          poll_cnt_d = '0;
          gap_cnt_d  = GAP_LOAD;
          state_d    = ST_POLL_GAP;
        end
        ST_POLL_GAP: begin
          if (gap_cnt_q == '0) state_d = ST_POLL_RD;
          else                 gap_cnt_d = gap_cnt_q - 1'b1;
        end
        ST_POLL_RD: state_d = ST_POLL_CHK;
        ST_POLL_CHK: begin
          if (rdata_i[4]) begin
            err_code_d = 2'b01;
            state_d    = ST_ERR;
          end else if (rdata_i[0]) begin
            idx_d   = '0;
            state_d = ST_HASH_RD;
          end else begin
            poll_cnt_d = poll_inc;
            if (poll_inc == POLL_LIMIT) begin
              err_code_d = 2'b10;
              state_d    = ST_ERR;
            end else begin
              gap_cnt_d = GAP_LOAD;
              state_d   = ST_POLL_GAP;
            end
          end
        end
        ST_HASH_RD: state_d = ST_HASH_CAP;
        ST_HASH_CAP: begin
          if (idx_q == IDX_LAST) state_d = ST_IDLE;
          else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_HASH_RD;
          end
        end
        ST_ERR:  state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // bus strobes and host-side outputs, all decoded from the current state
  always_comb begin
    msg_ready_o    = 1'b0;
    digest_valid_o = 1'b0;
    digest_word_o  = '0;
    digest_idx_o   = '0;
    done_o         = 1'b0;
    err_o          = 1'b0;
    wr_o           = 1'b0;
    waddr_o        = '0;
    wdata_o        = '0;
    rd_o           = 1'b0;
    raddr_o        = '0;
    busy_o         = (state_q != ST_IDLE);
    err_code_o     = err_code_q;
    if (!abort_act) begin
      unique case (state_q)
        ST_CFG: begin
          wr_o         = 1'b1;
          waddr_o      = ADDR_CFG;
          wdata_o[3:0] = opcode_q;
        end
        ST_START: begin
          wr_o       = 1'b1;
          waddr_o    = ADDR_CTL;
          wdata_o[0] = 1'b1;
        end
        ST_DATA: begin
          msg_ready_o = msg_valid_i && wr_ack_i;
          if (msg_valid_i && wr_ack_i) begin
            wr_o    = 1'b1;
            waddr_o = ADDR_DIN;
            wdata_o = msg_data_i;
          end
        end
        ST_LAST: begin
          wr_o       = 1'b1;
          waddr_o    = ADDR_CTL;
          wdata_o[1] = 1'b1;
        end
        ST_POLL_RD: begin
          rd_o    = 1'b1;
          raddr_o = ADDR_STS;
        end
        ST_HASH_RD: begin
          rd_o    = 1'b1;
          raddr_o = ADDR_HASH + {6'd0, idx_q, 2'b00};
        end
        ST_HASH_CAP: begin
          digest_valid_o = 1'b1;
          digest_word_o  = rdata_i;
          digest_idx_o   = idx_q;
          done_o         = (idx_q == IDX_LAST);
        end
        ST_ERR: begin
          err_o      = 1'b1;
          wr_o       = 1'b1;
          waddr_o    = ADDR_CTL;
          wdata_o[2] = 1'b1;
        end
        default: ;
      endcase
    end
    wbyte_enable_o = wr_o ? 4'hF : 4'h0;
  end

endmodule

// File: tb/tb_lw_sha_host_sequencer.sv
// Self-checking bench for lw_sha_host_sequencer: the bench acts as the SHA register slave
// and host, logs bus/host activity and compares against transaction lists built per job.
module tb_lw_sha_host_sequencer;

  localparam int unsigned DW = 8;
  localparam int unsigned PT = 4;
  localparam int unsigned PG = 2;
  localparam logic [11:0] A_CFG  = 12'h010;
  localparam logic [11:0] A_CTL  = 12'h020;
  localparam logic [11:0] A_STS  = 12'h030;
  localparam logic [11:0] A_HASH = 12'h100;
  localparam logic [11:0] A_DIN  = 12'h140;

  logic        clk_i = 1'b0;
  logic        resetn_i;
  logic        cmd_start_i;
  logic [3:0]  opcode_i;
  logic        abort_i;
  logic        msg_valid_i;
  logic [31:0] msg_data_i;
  logic        msg_last_i;
  logic        msg_ready_o;
  logic        digest_valid_o;
  logic [31:0] digest_word_o;
  logic [3:0]  digest_idx_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [1:0]  err_code_o;
  logic        wr_o;
  logic [11:0] waddr_o;
  logic [31:0] wdata_o;
  logic [3:0]  wbyte_enable_o;
  logic        wr_ack_i;
  logic        rd_o;
  logic [11:0] raddr_o;
  logic [31:0] rdata_i;

  always #5 clk_i = ~clk_i;

  lw_sha_host_sequencer #(
    .BUS_DATA_WIDTH(32),
    .DIGEST_WORDS(DW),
    .POLL_TIMEOUT(PT),
    .POLL_GAP(PG)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .cmd_start_i(cmd_start_i), .opcode_i(opcode_i),
    .abort_i(abort_i), .msg_valid_i(msg_valid_i), .msg_data_i(msg_data_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o), .digest_valid_o(digest_valid_o),
    .digest_word_o(digest_word_o), .digest_idx_o(digest_idx_o), .busy_o(busy_o),
    .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o), .wr_o(wr_o),
    .waddr_o(waddr_o), .wdata_o(wdata_o), .wbyte_enable_o(wbyte_enable_o),
    .wr_ack_i(wr_ack_i), .rd_o(rd_o), .raddr_o(raddr_o), .rdata_i(rdata_i)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [43:0] wr_log[$];
  logic [11:0] rd_log[$];
  logic [35:0] dg_log[$];
  int unsigned done_cnt, err_cnt, proto_bad;
  logic [1:0]  err_code_seen;
  logic [1:0]  last_code;
  bit          job_end, last_ready;

  logic [31:0] hash_mem[16];
  logic [31:0] job_words[$];
  int unsigned sts_polls, sts_event;
  bit          sts_fault, rd_pend, rst_on_hash, rst_hit;
  logic [11:0] rd_pend_addr;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit outs_zero();
    return ({wr_o, waddr_o, wdata_o, wbyte_enable_o, rd_o, raddr_o, msg_ready_o,
             digest_valid_o, digest_word_o, digest_idx_o, busy_o, done_o, err_o,
             err_code_o} === '0);
  endfunction

  // One clock: sample at negedge, then act as the slave for a read issued this cycle.
  task automatic cycle();
    @(negedge clk_i);
    last_ready = msg_ready_o;
    if (wr_o) wr_log.push_back({waddr_o, wdata_o});
    if (rd_o) rd_log.push_back(raddr_o);
    if (digest_valid_o) dg_log.push_back({digest_idx_o, digest_word_o});
    if (done_o) begin done_cnt++; job_end = 1; end
    if (err_o) begin err_cnt++; err_code_seen = err_code_o; job_end = 1; end
    if (wbyte_enable_o !== (wr_o ? 4'hF : 4'h0)) proto_bad++;
    if (!wr_o && (waddr_o !== '0 || wdata_o !== '0)) proto_bad++;
    if (!rd_o && raddr_o !== '0) proto_bad++;
    if (wr_o && rd_o) proto_bad++;
    if (!digest_valid_o && (digest_word_o !== '0 || digest_idx_o !== '0)) proto_bad++;
    rd_pend = rd_o;
    rd_pend_addr = raddr_o;
    if (rst_on_hash && rd_o && raddr_o == A_HASH) begin
      resetn_i = 1'b0;
      #1;
      check("outputs_zero_in_async_reset", 64'(outs_zero()), 64'd1);
      rst_hit = 1; job_end = 1; rd_pend = 0;
    end
    @(posedge clk_i);
    #1;
    if (rd_pend && rd_pend_addr == A_STS) begin
      sts_polls++;
      rdata_i = $urandom & ~32'h11;
      if (sts_polls == sts_event) rdata_i = sts_fault ? 32'h11 : (rdata_i | 32'h1);
    end else if (rd_pend && rd_pend_addr >= A_HASH && rd_pend_addr < A_HASH + 12'd64) begin
      rdata_i = hash_mem[int'((rd_pend_addr - A_HASH) >> 2)];
    end else begin
      rdata_i = $urandom;
    end
  endtask

  // ack_mode: 0 always ready, 1 pattern 1,0,0,1, 2 random. done_poll 0 = never done.
  task automatic run_job(input logic [3:0] op, input int ack_mode, input int done_poll,
                         input bit fault, input int abort_word, input bit rst_hash,
                         input bit noise);
    logic [43:0] exp_wr[$];
    logic [11:0] exp_rd[$];
    logic [35:0] exp_dg[$];
    int nw, wi, c, npolls, k;
    bit ack, acc, ab, aborted;
    logic [1:0] exp_code;
    int exp_done, exp_err;

    nw = job_words.size();
    wr_log.delete(); rd_log.delete(); dg_log.delete();
    done_cnt = 0; err_cnt = 0; proto_bad = 0; err_code_seen = '0; job_end = 0;
    sts_polls = 0; sts_event = done_poll; sts_fault = fault;
    rst_on_hash = rst_hash; rst_hit = 0;

    // abort in idle must not start anything; err code still held from previous job
    abort_i = 1'b1;
    cycle();
    abort_i = 1'b0;
    check("err_code_held_idle", 64'(err_code_o), 64'(last_code));

    cmd_start_i = 1'b1;
    opcode_i = op;
    cycle();
    cmd_start_i = 1'b0;
    opcode_i = 4'($urandom);
    check("busy_after_start", 64'(busy_o), 64'd1);

    wi = 0; c = 0; aborted = 0; k = 0;
    while (wi < nw && !aborted && c < 200) begin
      msg_valid_i = (ack_mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (ack_mode == 0) ack = 1;
      else if (ack_mode == 1) begin
        k = c - 2;
        ack = (c < 2) ? 1'b1 : ((k % 4 == 0) || (k % 4 == 3));
      end else ack = 1'($urandom_range(0, 1));
      ab = (abort_word >= 0) && (c >= 2) && (wi == abort_word) && ack;
      if (ab) msg_valid_i = 1'b1;
      wr_ack_i = ack;
      abort_i = ab;
      msg_data_i = job_words[wi];
      msg_last_i = (wi == nw - 1) || (!(msg_valid_i && ack) && $urandom_range(0, 1) == 1);
      cmd_start_i = noise && ($urandom_range(0, 3) == 0);
      opcode_i = 4'($urandom);
      acc = (c >= 2) && msg_valid_i && ack && !ab;
      cycle();
      if (last_ready !== acc) proto_bad++;
      if (acc) wi++;
      if (ab) aborted = 1;
      c++;
    end
    msg_valid_i = 1'b0; msg_last_i = 1'b0; abort_i = 1'b0; cmd_start_i = 1'b0;
    wr_ack_i = 1'($urandom_range(0, 1));

    c = 0;
    while (!job_end && c < 400) begin
      if (noise) begin
        msg_valid_i = 1'($urandom_range(0, 1));
        msg_last_i = 1'($urandom_range(0, 1));
        cmd_start_i = ($urandom_range(0, 3) == 0);
        opcode_i = 4'($urandom);
      end
      cycle();
      if (last_ready) proto_bad++;
      c++;
    end
    msg_valid_i = 1'b0; msg_last_i = 1'b0; cmd_start_i = 1'b0;
    check("job_end_within_budget", 64'(job_end), 64'd1);
    if (rst_hash) begin
      check("reset_hit_hash_rd", 64'(rst_hit), 64'd1);
      resetn_i = 1'b1;
    end
    check("busy_clear_after_job", 64'(busy_o), 64'd0);

    // expected transactions
    exp_wr.push_back({A_CFG, 28'h0, op});
    exp_wr.push_back({A_CTL, 32'h1});
    exp_done = 0; exp_err = 0; exp_code = 2'b00;
    if (abort_word >= 0) begin
      for (int i = 0; i < abort_word; i++) exp_wr.push_back({A_DIN, job_words[i]});
      exp_wr.push_back({A_CTL, 32'h4});
      exp_err = 1; exp_code = 2'b11;
    end else begin
      for (int i = 0; i < nw; i++) exp_wr.push_back({A_DIN, job_words[i]});
      exp_wr.push_back({A_CTL, 32'h2});
      npolls = (done_poll == 0 || done_poll > int'(PT)) ? int'(PT) : done_poll;
      for (int i = 0; i < npolls; i++) exp_rd.push_back(A_STS);
      if (done_poll == 0 || done_poll > int'(PT)) begin
        exp_wr.push_back({A_CTL, 32'h4}); exp_err = 1; exp_code = 2'b10;
      end else if (fault) begin
        exp_wr.push_back({A_CTL, 32'h4}); exp_err = 1; exp_code = 2'b01;
      end else if (rst_hash) begin
        exp_rd.push_back(A_HASH);
      end else begin
        for (int i = 0; i < int'(DW); i++) begin
          exp_rd.push_back(A_HASH + 12'(4 * i));
          exp_dg.push_back({4'(i), hash_mem[i]});
        end
        exp_done = 1;
      end
    end

    check("wr_count", 64'(wr_log.size()), 64'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_log.size(); i++)
      check($sformatf("wr[%0d]", i), 64'(wr_log[i]), 64'(exp_wr[i]));
    check("rd_count", 64'(rd_log.size()), 64'(exp_rd.size()));
    for (int i = 0; i < exp_rd.size() && i < rd_log.size(); i++)
      check($sformatf("rd[%0d]", i), 64'(rd_log[i]), 64'(exp_rd[i]));
    check("digest_count", 64'(dg_log.size()), 64'(exp_dg.size()));
    for (int i = 0; i < exp_dg.size() && i < dg_log.size(); i++)
      check($sformatf("digest[%0d]", i), 64'(dg_log[i]), 64'(exp_dg[i]));
    check("done_pulses", 64'(done_cnt), 64'(exp_done));
    check("err_pulses", 64'(err_cnt), 64'(exp_err));
    if (exp_err != 0) check("err_code_at_pulse", 64'(err_code_seen), 64'(exp_code));
    check("err_code_after_job", 64'(err_code_o), 64'(exp_code));
    check("protocol_violations", 64'(proto_bad), 64'd0);
    last_code = exp_code;
  endtask

  initial begin
    resetn_i = 1'b0; cmd_start_i = 1'b0; opcode_i = '0; abort_i = 1'b0;
    msg_valid_i = 1'b0; msg_data_i = '0; msg_last_i = 1'b0; wr_ack_i = 1'b0; rdata_i = '0;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outputs_zero", 64'(outs_zero()), 64'd1);
    resetn_i = 1'b1;
    @(posedge clk_i);
    #1;
    last_code = 2'b00;

    // basic job: done on 2nd poll, digest words 0x1000+i
    job_words = '{32'hA1, 32'hB2, 32'hC3};
    for (int i = 0; i < 16; i++) hash_mem[i] = 32'h1000 + 32'(i);
    run_job(4'h2, 0, 2, 0, -1, 0, 0);

    // wr_ack pattern 1,0,0,1 with valid held
    job_words = '{$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 16; i++) hash_mem[i] = $urandom;
    run_job(4'h5, 1, 1, 0, -1, 0, 0);

    // STS never done: timeout after PT polls
    job_words = '{$urandom, $urandom};
    run_job(4'h7, 0, 0, 0, -1, 0, 0);

    // fault and done together on the 2nd poll
    job_words = '{$urandom};
    run_job(4'h1, 0, 2, 1, -1, 0, 0);

    // abort on an acceptable-looking word, then a normal job
    job_words = '{$urandom, $urandom, $urandom};
    run_job(4'h3, 0, 1, 0, 1, 0, 0);
    job_words = '{$urandom, $urandom};
    run_job(4'h4, 0, 1, 0, -1, 0, 0);

    // async reset during HASH_RD, then a normal job restarts with CFG
    job_words = '{$urandom, $urandom};
    run_job(4'h9, 0, 1, 0, -1, 1, 0);
    job_words = '{$urandom};
    run_job(4'hA, 0, 3, 0, -1, 0, 0);

    // random jobs with host-side noise
    for (int j = 0; j < 8; j++) begin
      job_words.delete();
      for (int i = 0; i < int'($urandom_range(1, 6)); i++) job_words.push_back($urandom);
      for (int i = 0; i < 16; i++) hash_mem[i] = $urandom;
      run_job(4'($urandom), 2, int'($urandom_range(1, PT + 1)), ($urandom_range(0, 3) == 0),
              -1, 0, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
